ex_muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit with its own sequencing FSM. Shares the Execute

---
 rtl/ex_muldiv_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_sequencer
// Description : Iterative RV32M multiply/divide unit for the Execute stage.
//               It uses a shift-add multiplier and a restoring divider, and
//               stalls the pipeline until its single result pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid_ip,
    input  logic [2:0]      req_op_ip,
    input  logic [XLEN-1:0] operand_a_ip,
    input  logic [XLEN-1:0] operand_b_ip,
    input  logic [4:0]      req_rd_ip,
    input  logic            flush_ip,
    output logic            stall_op,
    output logic            busy_op,
    output logic [XLEN-1:0] result_op,
    output logic            result_valid_op,
    output logic [4:0]      result_rd_op
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0]       C_OP_MUL    = 3'd0;
    localparam logic [2:0]       C_OP_MULH   = 3'd1;
    localparam logic [2:0]       C_OP_MULHSU = 3'd2;
    localparam logic [2:0]       C_OP_MULHU  = 3'd3;
    localparam logic [2:0]       C_OP_DIV    = 3'd4;
    localparam logic [2:0]       C_OP_DIVU   = 3'd5;
    localparam logic [2:0]       C_OP_REM    = 3'd6;
    localparam logic [XLEN-1:0]  C_MIN       = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(XLEN-1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;

    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic              w_special, w_accept, w_div_ge;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
    logic [XLEN-1:0]   w_div_diff, w_quo_fix, w_rem_fix;
    logic [XLEN:0]     w_mul_sum, w_div_shift;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    assign w_a_signed = req_op_ip inside {C_OP_MUL, C_OP_MULH, C_OP_MULHSU, C_OP_DIV, C_OP_REM};
    assign w_b_signed = req_op_ip inside {C_OP_MUL, C_OP_MULH, C_OP_DIV, C_OP_REM};
    assign w_a_neg    = w_a_signed & operand_a_ip[XLEN-1];
    assign w_b_neg    = w_b_signed & operand_b_ip[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~operand_a_ip + 1'b1) : operand_a_ip;
    assign w_b_mag    = w_b_neg ? (~operand_b_ip + 1'b1) : operand_b_ip;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign w_special = req_op_ip[2] & ((operand_b_ip == '0) |
                       (~req_op_ip[0] & (operand_a_ip == C_MIN) & (operand_b_ip == '1)));
    assign w_special_res = (operand_b_ip == '0) ? (req_op_ip[1] ? operand_a_ip : '1)
                                                : (req_op_ip[1] ? '0 : C_MIN);
    assign w_accept = req_valid_ip & (state_q == S_IDLE) & ~flush_ip;

    // hi:lo is the product for MUL*, and remainder:quotient for DIV*/REM*.
    assign w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_div_shift = {hi_q, lo_q[XLEN-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, opnd_q};
    assign w_div_diff  = w_div_shift[XLEN-1:0] - opnd_q;
    assign w_prod      = {hi_q, lo_q};
    assign w_prod_fix  = neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix   = neg_q ? (~lo_q + 1'b1) : lo_q;
    assign w_rem_fix   = neg_q ? (~hi_q + 1'b1) : hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d  = req_op_ip;
                    rd_d  = req_rd_ip;
                    cnt_d = '0;
                    hi_d  = '0;
                    neg_d = (req_op_ip == C_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
                    if (req_op_ip[2]) begin
                        lo_d   = w_a_mag;
                        opnd_d = w_b_mag;
                    end else begin
                        lo_d   = w_b_mag;
                        opnd_d = w_a_mag;
                    end
                    if (w_special) begin
                        result_d = w_special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (op_q[2]) begin
                    hi_d = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], w_div_ge};
                end else begin
                    hi_d = w_mul_sum[XLEN:1];
                    lo_d = {w_mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                case (op_q)
                    C_OP_MUL:                          result_d = w_prod_fix[XLEN-1:0];
                    C_OP_MULH, C_OP_MULHSU, C_OP_MULHU: result_d = w_prod_fix[2*XLEN-1:XLEN];
                    C_OP_DIV, C_OP_DIVU:               result_d = w_quo_fix;
                    default:                           result_d = w_rem_fix;
                endcase
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush_ip) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
        end
    end

    // Stall drops in DONE so EX advances exactly as the result is captured.
    assign stall_op        = ~reset & req_valid_ip & (state_q != S_DONE);
    assign busy_op         = (state_q != S_IDLE);
    assign result_valid_op = (state_q == S_DONE) & ~flush_ip;
    assign result_op       = result_q;
    assign result_rd_op    = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_sequencer
// Description : Self-checking bench for ex_muldiv_sequencer: directed vector
//               table, random ops against an arithmetic model, corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid_ip;
    logic [2:0]  req_op_ip;
    logic [31:0] operand_a_ip;
    logic [31:0] operand_b_ip;
    logic [4:0]  req_rd_ip;
    logic        flush_ip;
    logic        stall_op;
    logic        busy_op;
    logic [31:0] result_op;
    logic        result_valid_op;
    logic [4:0]  result_rd_op;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[18];

    ex_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid_ip    (req_valid_ip),
        .req_op_ip       (req_op_ip),
        .operand_a_ip    (operand_a_ip),
        .operand_b_ip    (operand_b_ip),
        .req_rd_ip       (req_rd_ip),
        .flush_ip        (flush_ip),
        .stall_op        (stall_op),
        .busy_op         (busy_op),
        .result_op       (result_op),
        .result_valid_op (result_valid_op),
        .result_rd_op    (result_rd_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics from plain arithmetic on wide integers.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, sp;
        logic [63:0]        up;
        int                 ia, ib, iq;
        sa = $signed(a);
        sb = $signed(b);
        ub = $signed({32'h0, b});
        ia = a;
        ib = b;
        case (op)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * ub; return sp[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                iq = ia / ib;
                return iq;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                iq = ia % ib;
                return iq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Presents one request, waits for its pulse, then retires it from EX.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int         lat;
        int         stall_low;
        logic [4:0] rd;
        rd = 5'($urandom);
        @(negedge clock);
        req_valid_ip = 1'b1;
        req_op_ip    = op;
        operand_a_ip = a;
        operand_b_ip = b;
        req_rd_ip    = rd;
        #1;
        stall_low = (stall_op !== 1'b1) ? 1 : 0;
        lat = 0;
        while (lat < 60) begin
            @(negedge clock);
            lat++;
            if (result_valid_op === 1'b1) break;
            if (stall_op !== 1'b1) stall_low++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result_op, exp_res);
        check({name, " rd"}, {27'h0, result_rd_op}, {27'h0, rd});
        check({name, " stall_done"}, {31'h0, stall_op}, 32'h0);
        check({name, " stall_low_cycles"}, 32'(stall_low), 32'h0);
        req_valid_ip = 1'b0;
    endtask

    initial begin
        int p1, p2, pulses;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        tbl[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        tbl[8]  = '{3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
        tbl[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1};
        tbl[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 34};
        tbl[15] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
        tbl[16] = '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
        tbl[17] = '{3'd4, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 34};

        reset        = 1'b1;
        req_valid_ip = 1'b0;
        req_op_ip    = 3'd0;
        operand_a_ip = 32'h0;
        operand_b_ip = 32'h0;
        req_rd_ip    = 5'd0;
        flush_ip     = 1'b0;
        repeat (3) @(negedge clock);
        check("reset stall", {31'h0, stall_op}, 32'h0);
        check("reset busy", {31'h0, busy_op}, 32'h0);
        check("reset valid", {31'h0, result_valid_op}, 32'h0);
        check("reset result", result_op, 32'h0);
        check("reset rd", {27'h0, result_rd_op}, 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(0, 15));
                2:       rb = 32'h0 - 32'($urandom_range(1, 15));
                default: rb = 32'h0;
            endcase
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb));
        end

        // Flush while running: no result, back to idle next cycle.
        @(negedge clock);
        req_valid_ip = 1'b1; req_op_ip = 3'd0; operand_a_ip = 32'd3; operand_b_ip = 32'd4;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (result_valid_op === 1'b1) pulses++;
        end
        flush_ip = 1'b1; req_valid_ip = 1'b0;
        #1;
        if (result_valid_op === 1'b1) pulses++;
        @(negedge clock);
        flush_ip = 1'b0;
        #1;
        check("flush_run busy", {31'h0, busy_op}, 32'h0);
        check("flush_run stall", {31'h0, stall_op}, 32'h0);
        repeat (40) begin
            @(negedge clock);
            if (result_valid_op === 1'b1) pulses++;
        end
        check("flush_run pulses", 32'(pulses), 32'h0);

        // Flush in the DONE cycle suppresses the pulse.
        @(negedge clock);
        req_valid_ip = 1'b1; req_op_ip = 3'd5; operand_a_ip = 32'd100; operand_b_ip = 32'd7;
        pulses = 0;
        repeat (33) begin
            @(negedge clock);
            if (result_valid_op === 1'b1) pulses++;
        end
        @(negedge clock);
        flush_ip = 1'b1;
        #1;
        if (result_valid_op === 1'b1) pulses++;
        check("flush_done pulses", 32'(pulses), 32'h0);
        @(negedge clock);
        flush_ip = 1'b0; req_valid_ip = 1'b0;
        #1;
        check("flush_done busy", {31'h0, busy_op}, 32'h0);

        // Flush coincident with a request: not accepted.
        @(negedge clock);
        req_valid_ip = 1'b1; flush_ip = 1'b1; req_op_ip = 3'd4; operand_a_ip = 32'd100; operand_b_ip = 32'd7;
        @(negedge clock);
        check("flush_req busy", {31'h0, busy_op}, 32'h0);
        req_valid_ip = 1'b0; flush_ip = 1'b0;

        // Back-to-back MULs: second accepted the cycle after the first DONE.
        @(negedge clock);
        req_valid_ip = 1'b1; req_op_ip = 3'd0; operand_a_ip = 32'd3; operand_b_ip = 32'd5;
        p1 = -1; p2 = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clock);
            if (result_valid_op === 1'b1) begin
                if (p1 < 0) begin
                    p1 = cyc;
                    check("b2b first result", result_op, 32'd15);
                    operand_a_ip = 32'd6; operand_b_ip = 32'd7;
                end else begin
                    p2 = cyc;
                    check("b2b second result", result_op, 32'd42);
                    break;
                end
            end
        end
        req_valid_ip = 1'b0;
        check("b2b first cycle", 32'(p1), 32'd34);
        check("b2b spacing", 32'(p2 - p1), 32'd35);

        // Reset mid-operation clears everything.
        @(negedge clock);
        req_valid_ip = 1'b1; req_op_ip = 3'd0; operand_a_ip = 32'd9; operand_b_ip = 32'd9; req_rd_ip = 5'd9;
        repeat (20) @(negedge clock);
        reset = 1'b1; req_valid_ip = 1'b0;
        @(negedge clock);
        check("midreset busy", {31'h0, busy_op}, 32'h0);
        check("midreset stall", {31'h0, stall_op}, 32'h0);
        check("midreset valid", {31'h0, result_valid_op}, 32'h0);
        check("midreset result", result_op, 32'h0);
        check("midreset rd", {27'h0, result_rd_op}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
